// File: rtl/online_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : online_div_arbiter
//  Purpose  : Shares one online digit-serial divider between NUM_REQ
//             requesters. A round-robin arbiter grants the divider and clears
//             it for one cycle. It then muxes the winner's radix-2
//             signed-digit streams onto the divider and returns digit-read
//             strobes to the winner. Job completion is detected by counting
//             FINISH_COUNT rising edges of the divider's finish_vec.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1           clock
//    asyn_reset      in   1           asynchronous active-high reset
//    req             in   NUM_REQ     per-requester level request
//    x_in / y_in     in   2*NUM_REQ   packed dividend / divisor digits,
//                                     requester i on bits [2i+1:2i]
//    div_enable      in   1           divider consumed a digit this cycle
//    div_finish_vec  in   1           divider finish_vec
//    div_reset       out  1           registered divider clear pulse
//    div_enable_comp out  1           divider run enable
//    div_x / div_y   out  2           muxed dividend / divisor digit
//    digit_rd        out  NUM_REQ     one-hot digit-consumed strobe
//    grant           out  NUM_REQ     one-hot current owner
//    grant_idx       out  GRANT_W     binary index of the owner
//    done            out  NUM_REQ     one-cycle completion pulse to owner
//    busy            out  1           arbiter not idle
// ============================================================================
module online_div_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FINISH_COUNT = 4,
  parameter int GRANT_W      = 2
) (
  input  logic                   clk,
  input  logic                   asyn_reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   x_in,
  input  logic [2*NUM_REQ-1:0]   y_in,
  input  logic                   div_enable,
  input  logic                   div_finish_vec,
  output logic                   div_reset,
  output logic                   div_enable_comp,
  output logic [1:0]             div_x,
  output logic [1:0]             div_y,
  output logic [NUM_REQ-1:0]     digit_rd,
  output logic [NUM_REQ-1:0]     grant,
  output logic [GRANT_W-1:0]     grant_idx,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   last_idx_q, last_idx_d;
  logic [GRANT_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           fin_cnt_q, fin_cnt_d;
  logic                 fin_prev_q, fin_prev_d;
  logic                 div_reset_q, div_reset_d;

  // Round-robin search, starting one past the last owner.
  int                   rr_cand;
  logic [GRANT_W-1:0]   rr_cand_idx;
  logic                 rr_found;
  logic [GRANT_W-1:0]   rr_idx;

  always_comb begin
    rr_found    = 1'b0;
    rr_idx      = '0;
    rr_cand     = 0;
    rr_cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = int'(last_idx_q) + k;
      if (rr_cand >= NUM_REQ) rr_cand = rr_cand - NUM_REQ;
      rr_cand_idx = GRANT_W'(rr_cand);
      if (!rr_found && req[rr_cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand_idx;
      end
    end
  end

  // A finish_vec level held over several cycles counts as one edge.
  logic       fin_edge;
  logic [7:0] fin_cnt_inc;
  logic       fin_last;

  assign fin_edge    = div_finish_vec & ~fin_prev_q;
  assign fin_cnt_inc = fin_cnt_q + 8'd1;
  assign fin_last    = fin_edge && (fin_cnt_inc == 8'(FINISH_COUNT));

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    fin_cnt_d   = fin_cnt_q;
    fin_prev_d  = div_finish_vec;
    div_reset_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d     = NUM_REQ'(1) << rr_idx;
          grant_idx_d = rr_idx;
          div_reset_d = 1'b1;     // div_reset is high exactly in CLEAR
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fin_cnt_d  = '0;
        fin_prev_d = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (fin_edge) fin_cnt_d = fin_cnt_inc;
        // Completion takes priority over a simultaneous request drop.
        if (fin_last) begin
          state_d = S_DONE;
        end else if (!req[grant_idx_q]) begin
          last_idx_d  = grant_idx_q;
          grant_d     = '0;
          grant_idx_d = '0;
          state_d     = S_IDLE;
        end
      end
      S_DONE: begin
        last_idx_d  = grant_idx_q;
        grant_d     = '0;
        grant_idx_d = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q     <= S_IDLE;
      last_idx_q  <= GRANT_W'(NUM_REQ - 1);
      grant_q     <= '0;
      grant_idx_q <= '0;
      fin_cnt_q   <= '0;
      fin_prev_q  <= 1'b0;
      div_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      fin_cnt_q   <= fin_cnt_d;
      fin_prev_q  <= fin_prev_d;
      div_reset_q <= div_reset_d;
    end
  end

  // Digit mux: only the owner's slice reaches the divider, and only in RUN.
  always_comb begin
    div_x = '0;
    div_y = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx_q == GRANT_W'(i)) begin
          div_x = x_in[2*i +: 2];
          div_y = y_in[2*i +: 2];
        end
      end
    end
  end

  assign div_reset       = div_reset_q;
  assign div_enable_comp = (state_q == S_RUN);
  assign digit_rd        = ((state_q == S_RUN) && div_enable) ? grant_q : '0;
  assign grant           = grant_q;
  assign grant_idx       = grant_idx_q;
  assign done            = (state_q == S_DONE) ? grant_q : '0;
  assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_online_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_online_div_arbiter
//  Purpose  : Self-checking bench for online_div_arbiter (NUM_REQ=4,
//             FINISH_COUNT=4). Inputs change 1 time unit after the rising
//             edge; outputs are compared at that same point.
//  Revision : 1.0  initial release
// ============================================================================
module tb_online_div_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic [NR-1:0] req;
  logic [7:0]    x_in, y_in;
  logic          div_enable, div_finish_vec;
  logic          div_reset, div_enable_comp;
  logic [1:0]    div_x, div_y;
  logic [NR-1:0] digit_rd, grant, done;
  logic [1:0]    grant_idx;
  logic          busy;

  always #5 clk = ~clk;

  online_div_arbiter #(.NUM_REQ(NR), .FINISH_COUNT(4), .GRANT_W(2)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .req(req), .x_in(x_in), .y_in(y_in),
    .div_enable(div_enable), .div_finish_vec(div_finish_vec),
    .div_reset(div_reset), .div_enable_comp(div_enable_comp),
    .div_x(div_x), .div_y(div_y), .digit_rd(digit_rd), .grant(grant),
    .grant_idx(grant_idx), .done(done), .busy(busy)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       en;
    logic [1:0] ex;
    logic [1:0] ey;
    logic [3:0] erd;
  } vec_t;

  vec_t tbl [4];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    asyn_reset     = 1'b1;
    req            = '0;
    div_finish_vec = 1'b0;
    div_enable     = 1'b0;
    tick();
    tick();
    asyn_reset = 1'b0;
  endtask

  // Raise req in IDLE; expect one CLEAR cycle with the given owner, then RUN.
  task automatic start_job(input logic [3:0] rv, input logic [3:0] eg,
                           input logic [1:0] ei, input string tag);
    req = rv;
    tick();
    chk({tag, "_clr_grant"}, grant, eg);
    chk({tag, "_clr_idx"}, grant_idx, ei);
    chk({tag, "_clr_divreset"}, div_reset, 1);
    chk({tag, "_clr_encomp"}, div_enable_comp, 0);
    tick();
    chk({tag, "_run_divreset"}, div_reset, 0);
    chk({tag, "_run_encomp"}, div_enable_comp, 1);
    chk({tag, "_run_grant"}, grant, eg);
  endtask

  // Produce n finish edges (non-final ones held 'hold' cycles); done must
  // appear only the cycle after the last edge, then the owner drops req.
  task automatic finish_job(input int n, input int hold, input logic [3:0] g,
                            input bit drop_on_last, input string tag);
    int early = 0;
    for (int e = 1; e <= n; e++) begin
      div_finish_vec = 1'b1;
      if (e == n) begin
        if (drop_on_last) req = req & ~g;
        tick();
        chk({tag, "_done"}, done, g);
        chk({tag, "_done_encomp"}, div_enable_comp, 0);
        chk({tag, "_done_busy"}, busy, 1);
      end else begin
        for (int h = 0; h < hold; h++) begin
          tick();
          if (done != 0) early++;
        end
        div_finish_vec = 1'b0;
        tick();
        if (done != 0) early++;
        tick();
        if (done != 0) early++;
      end
    end
    chk({tag, "_no_early_done"}, early, 0);
    div_finish_vec = 1'b0;
    req = req & ~g;
    tick();
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_grant"}, grant, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_err;
    int early;

    tbl[0] = '{8'hE5, 8'h03, 1'b1, 2'b01, 2'b11, 4'b0001};
    tbl[1] = '{8'hFE, 8'h01, 1'b0, 2'b10, 2'b01, 4'b0000};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 2'b00, 2'b11, 4'b0001};
    tbl[3] = '{8'h57, 8'hAA, 1'b1, 2'b11, 2'b10, 4'b0001};

    x_in = 8'hFF;
    y_in = 8'hFF;
    asyn_reset = 1'b1;
    req = '0;
    div_finish_vec = 1'b0;
    div_enable = 1'b1;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divreset", div_reset, 0);
    chk("rst_encomp", div_enable_comp, 0);
    chk("rst_digit_rd", digit_rd, 0);
    chk("rst_div_x", div_x, 0);
    do_reset();

    // ---- single requester, long job, digit mux table ----
    start_job(4'b0001, 4'b0001, 2'd0, "single");
    foreach (tbl[i]) begin
      x_in = tbl[i].x;
      y_in = tbl[i].y;
      div_enable = tbl[i].en;
      #1;
      chk($sformatf("tbl%0d_div_x", i), div_x, tbl[i].ex);
      chk($sformatf("tbl%0d_div_y", i), div_y, tbl[i].ey);
      chk($sformatf("tbl%0d_digit_rd", i), digit_rd, tbl[i].erd);
    end
    rd_err = 0;
    early = 0;
    for (int c = 1; c <= 280; c++) begin
      div_finish_vec = (c % 70 == 0);
      div_enable = (c % 2 == 1);
      #1;
      if (digit_rd !== (div_enable ? 4'b0001 : 4'b0000)) rd_err++;
      tick();
      if (c == 280) chk("single_done", done, 4'b0001);
      else if (done != 0) early++;
    end
    chk("single_digit_rd_track", rd_err, 0);
    chk("single_no_early_done", early, 0);
    div_finish_vec = 1'b0;
    req = '0;
    tick();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_done", done, 0);
    div_enable = 1'b1;
    #1;
    chk("idle_digit_rd", digit_rd, 0);
    chk("idle_div_x", div_x, 0);
    chk("idle_encomp", div_enable_comp, 0);
    div_enable = 1'b0;

    // ---- contention ----
    do_reset();
    start_job(4'b0110, 4'b0010, 2'd1, "cont1");
    x_in = 8'b0000_1000;
    y_in = 8'b0000_0100;
    #1;
    chk("cont1_div_x_slice", div_x, 2'b10);
    chk("cont1_div_y_slice", div_y, 2'b01);
    finish_job(4, 1, 4'b0010, 1'b0, "cont1");
    start_job(4'b0100, 4'b0100, 2'd2, "cont2");
    finish_job(4, 1, 4'b0100, 1'b0, "cont2");
    start_job(4'b0110, 4'b0010, 2'd1, "cont3");
    finish_job(4, 1, 4'b0010, 1'b0, "cont3");
    req = '0;

    // ---- fairness ----
    do_reset();
    start_job(4'b1111, 4'b0001, 2'd0, "fair0");
    finish_job(4, 1, 4'b0001, 1'b0, "fair0");
    start_job(4'b1110, 4'b0010, 2'd1, "fair1");
    finish_job(4, 1, 4'b0010, 1'b0, "fair1");
    start_job(4'b1100, 4'b0100, 2'd2, "fair2");
    finish_job(4, 1, 4'b0100, 1'b0, "fair2");
    start_job(4'b1000, 4'b1000, 2'd3, "fair3");
    finish_job(4, 1, 4'b1000, 1'b0, "fair3");
    start_job(4'b1111, 4'b0001, 2'd0, "fair4");
    finish_job(4, 1, 4'b0001, 1'b0, "fair4");
    req = '0;

    // ---- finish_vec held high: each level counts once ----
    start_job(4'b0001, 4'b0001, 2'd0, "hold");
    finish_job(4, 3, 4'b0001, 1'b0, "hold");

    // ---- abort mid-RUN after one edge ----
    start_job(4'b0100, 4'b0100, 2'd2, "abort");
    div_finish_vec = 1'b1;
    tick();
    div_finish_vec = 1'b0;
    tick();
    req = '0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    chk("abort_encomp", div_enable_comp, 0);
    start_job(4'b1100, 4'b1000, 2'd3, "after_abort");
    // completion and req drop in the same cycle: completion wins
    finish_job(4, 1, 4'b1000, 1'b1, "drop_win");
    req = '0;

    // ---- async reset mid-RUN ----
    start_job(4'b0001, 4'b0001, 2'd0, "arst");
    tick();
    tick();
    #2;
    chk("arst_pre_encomp", div_enable_comp, 1);
    asyn_reset = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_encomp", div_enable_comp, 0);
    chk("arst_busy", busy, 0);
    chk("arst_divreset", div_reset, 0);
    tick();
    asyn_reset = 1'b0;
    start_job(4'b0001, 4'b0001, 2'd0, "arst_restart");
    finish_job(4, 1, 4'b0001, 1'b0, "arst_restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/online_div_arbiter.md
Name: online_div_arbiter

Overview:
- Shares one online digit-serial divider (the computation-control + datapath pair) between NUM_REQ requesters in the Newton datapath.
- Round-robin grants the divider, clears it before each job, muxes the winner's radix-2 signed-digit streams onto the divider inputs, and returns digit-read strobes to the winner.
- Counts divider finish_vec rising edges to detect job completion, then signals done to the winner.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FINISH_COUNT, 4, finish_vec rising edges per job (1..255).
- GRANT_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- asyn_reset  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester request, level; held until done.
- x_in  in  2*NUM_REQ  packed dividend digits; requester i uses bits [2i+1:2i].
- y_in  in  2*NUM_REQ  packed divisor digits, same packing.
- div_enable  in  1  divider's enable (digit consumed this cycle).
- div_finish_vec  in  1  divider's finish_vec.
- div_reset  out  1  registered clear pulse to divider reset.
- div_enable_comp  out  1  divider run enable.
- div_x  out  2  muxed dividend digit.
- div_y  out  2  muxed divisor digit.
- digit_rd  out  NUM_REQ  one-hot strobe: winner's digit consumed this cycle.
- grant  out  NUM_REQ  one-hot current owner.
- grant_idx  out  GRANT_W  binary index of the owner.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; last_idx=NUM_REQ-1; all outputs 0; finish counter 0; fin_d 0.
- States: IDLE, CLEAR, RUN, DONE; 2-bit encoded state register.
- IDLE:
  - If any req bit is set, select the first requester set in the order last_idx+1, last_idx+2, ..., wrapping modulo NUM_REQ.
  - Register grant and grant_idx; go to CLEAR.
  - The decision uses req sampled in the IDLE cycle.
- CLEAR: exactly one cycle.
  - div_reset=1, div_enable_comp=0.
  - Clear the finish counter and fin_d.
  - Next state is RUN.
- RUN:
  - div_enable_comp=1.
  - div_x/div_y are driven combinationally from the granted requester's x_in/y_in slice.
  - digit_rd = grant when div_enable=1, else 0.
  - Count rising edges of div_finish_vec (fin_d = registered previous value). A level held for several cycles counts once.
  - When the count reaches FINISH_COUNT (on the edge cycle), go to DONE.
  - Abort: if req[grant_idx] falls in RUN, go to IDLE directly. No done pulse; last_idx is updated to grant_idx; grant is cleared.
  - Completion and req drop in the same cycle: completion wins and the machine goes to DONE.
- DONE: one cycle.
  - done = grant for this cycle only.
  - div_enable_comp=0; last_idx <= grant_idx.
  - Then go to IDLE with grant=0.
  - The requester must drop req within one cycle of done, otherwise it is re-eligible under round-robin.
- Outside RUN: div_x=div_y=0, digit_rd=0, div_enable_comp=0.
- Outside CLEAR: div_reset=0.
- busy=1 in CLEAR, RUN and DONE.
- Latency:
  - req high in IDLE cycle t -> grant visible at t+1 (CLEAR).
  - First div_enable_comp at t+2.
  - done pulses 1 cycle after the FINISH_COUNT-th finish edge.
  - Next grant is possible 2 cycles after done (IDLE decision, then CLEAR).
- Reset asserted mid-RUN: everything is cleared immediately. div_reset is 0 after reset; the divider is assumed reset by the same asyn_reset net.

Test Plan:
- Single requester: req=0001, model finish_vec edges at cycles 70/140/210/280 -> done=0001 one cycle after the 4th edge; digit_rd tracks div_enable; div_x equals x_in[1:0].
- Contention: req=0110 from reset -> grant order is 0010, then 0100, then back to 0010 if re-requested. grant_idx matches. Exactly one CLEAR cycle precedes each RUN.
- Fairness: all four requesting continuously, each dropping req after its own done -> grants 0001, 0010, 0100, 1000, 0001.
- finish_vec held high 3 cycles, counted as one edge -> done is produced only after FINISH_COUNT distinct edges.
- Abort: drop req[2] mid-RUN after 1 edge -> no done; IDLE next cycle; the next grant goes to index 3 when req=1100.
- Async reset mid-RUN (div_enable_comp=1) -> same cycle: grant=0, div_enable_comp=0, busy=0. After release with req=0001, the full CLEAR/RUN sequence restarts.
